// File: rtl/serial_pkg.sv
// Shared definitions for the serial transmitter slice: frame length default and
// the count-width rule used by both the master and its sequence counter.
package serial_pkg;

  localparam int DEFAULT_MESSAGE_LENGTH = 8;

  // Width of a counter that must hold 0..2*msg_len+1; one spare bit is kept.
  function automatic int count_width(input int msg_len);
    return $clog2(2 * msg_len + 1) + 1;
  endfunction

endpackage

// File: rtl/sequence_counter.sv
// Free-running frame sequencer for the serial master: count/2 is the bit slot,
// count%2 the half-phase; wraps after the last half-phase of the frame.
module sequence_counter
  import serial_pkg::*;
#(
  parameter int MESSAGE_LENGTH = DEFAULT_MESSAGE_LENGTH,
  localparam int COUNT_W = count_width(MESSAGE_LENGTH)
) (
  input  logic               clk,
  input  logic               rst,
  output logic [COUNT_W-1:0] count
);

  localparam logic [COUNT_W-1:0] MAX_COUNT = COUNT_W'(2 * MESSAGE_LENGTH + 1);

  if (MESSAGE_LENGTH < 1) begin : g_bad_length
    $fatal(1, "sequence_counter: MESSAGE_LENGTH must be >= 1");
  end

  // Using >= rather than == sends any deposited out-of-range value back to 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (count >= MAX_COUNT) begin
      count <= '0;
    end else begin
      count <= count + COUNT_W'(1);
    end
  end

endmodule

// File: tb/tb_sequence_counter.sv
// Self-checking bench for sequence_counter at MESSAGE_LENGTH 8 (default), 1 and 16.
module tb_sequence_counter;

  logic       clk;
  logic       rst;
  logic [5:0] cnt8;
  logic [2:0] cnt1;
  logic [6:0] cnt16;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: the frame position of each instance, as a plain integer.
  int m8, m1, m16;

  sequence_counter dut8 (.clk(clk), .rst(rst), .count(cnt8));
  sequence_counter #(.MESSAGE_LENGTH(1))  dut1  (.clk(clk), .rst(rst), .count(cnt1));
  sequence_counter #(.MESSAGE_LENGTH(16)) dut16 (.clk(clk), .rst(rst), .count(cnt16));

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Frame of ml bits spans 2*ml+2 clocks: idle, start, then two half-phases per bit.
  function automatic int next_pos(input int cur, input int ml, input bit r);
    return r ? 0 : (cur + 1) % (2 * ml + 2);
  endfunction

  function automatic int expected_width(input int ml);
    int w = 0;
    while ((1 << w) < 2 * ml + 1) w++;
    return w + 1;
  endfunction

  // ---------------- driver ----------------
  task automatic step(input bit r);
    rst = r;
    @(posedge clk);
    m8  = next_pos(m8,  8,  r);
    m1  = next_pos(m1,  1,  r);
    m16 = next_pos(m16, 16, r);
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      step(1'b1);
      n_cmp++;
      if (cnt8 !== 6'd0 || cnt1 !== 3'd0 || cnt16 !== 7'd0) begin
        n_err++;
        $display("FAIL reset_hold edge %0d: got %0d/%0d/%0d want 0/0/0", i, cnt8, cnt1, cnt16);
      end
    end
  endtask

  task automatic test_count_up();
    for (int i = 1; i <= 10; i++) begin
      step(1'b0);
      n_cmp++;
      if (cnt8 !== 6'(i)) begin
        n_err++;
        $display("FAIL count_up step %0d: got %0d want %0d", i, cnt8, i);
      end
    end
  endtask

  task automatic test_wrap();
    int saw_max;
    int zero_after_max;
    step(1'b1);
    saw_max = 0;
    zero_after_max = 0;
    // Two full frames plus a few edges of the third.
    for (int i = 1; i <= 40; i++) begin
      step(1'b0);
      n_cmp++;
      if (cnt8 !== 6'(m8)) begin
        n_err++;
        $display("FAIL wrap edge %0d: got %0d want %0d", i, cnt8, m8);
      end
      if (saw_max == 1 && cnt8 === 6'd0) zero_after_max++;
      saw_max = (cnt8 === 6'd17) ? 1 : 0;
    end
    n_cmp++;
    if (zero_after_max != 2) begin
      n_err++;
      $display("FAIL wrap_17_to_0: got %0d wraps want 2", zero_after_max);
    end
    // Period check: edge 18*k after release lands on 0.
    step(1'b1);
    for (int i = 1; i <= 36; i++) step(1'b0);
    n_cmp++;
    if (cnt8 !== 6'd0) begin
      n_err++;
      $display("FAIL period_18: got %0d want 0 after 36 edges", cnt8);
    end
  endtask

  task automatic test_mid_reset();
    int budget;
    step(1'b1);
    budget = 0;
    while (m8 != 9 && budget < 40) begin
      step(1'b0);
      budget++;
    end
    n_cmp++;
    if (cnt8 !== 6'd9) begin
      n_err++;
      $display("FAIL mid_reset_reach9: got %0d want 9 (budget %0d)", cnt8, budget);
    end
    step(1'b1);
    n_cmp++;
    if (cnt8 !== 6'd0) begin
      n_err++;
      $display("FAIL mid_reset_force0: got %0d want 0", cnt8);
    end
    for (int i = 1; i <= 2; i++) begin
      step(1'b0);
      n_cmp++;
      if (cnt8 !== 6'(i)) begin
        n_err++;
        $display("FAIL mid_reset_release step %0d: got %0d want %0d", i, cnt8, i);
      end
    end
  endtask

  task automatic test_param_sweep();
    int w8, w1, w16;
    w8  = expected_width(8);
    w1  = expected_width(1);
    w16 = expected_width(16);
    n_cmp++;
    if ($bits(cnt8) != w8 || $bits(dut8.count) != w8) begin
      n_err++;
      $display("FAIL width_default: got %0d want %0d", $bits(dut8.count), w8);
    end
    n_cmp++;
    if ($bits(dut1.count) != w1 || $bits(dut16.count) != w16) begin
      n_err++;
      $display("FAIL width_sweep: got %0d/%0d want %0d/%0d", $bits(dut1.count), $bits(dut16.count), w1, w16);
    end
    step(1'b1);
    for (int i = 1; i <= 70; i++) begin
      step(1'b0);
      n_cmp++;
      if (cnt1 !== 3'(m1)) begin
        n_err++;
        $display("FAIL sweep_len1 edge %0d: got %0d want %0d", i, cnt1, m1);
      end
      n_cmp++;
      if (cnt16 !== 7'(m16)) begin
        n_err++;
        $display("FAIL sweep_len16 edge %0d: got %0d want %0d", i, cnt16, m16);
      end
    end
  endtask

  task automatic test_random();
    bit r;
    for (int i = 0; i < 1000; i++) begin
      r = ($urandom_range(0, 19) == 0);
      step(r);
      n_cmp++;
      if (cnt8 !== 6'(m8) || cnt1 !== 3'(m1) || cnt16 !== 7'(m16)) begin
        n_err++;
        $display("FAIL random cycle %0d rst=%0d: got %0d/%0d/%0d want %0d/%0d/%0d",
                 i, r, cnt8, cnt1, cnt16, m8, m1, m16);
      end
      n_cmp++;
      if (cnt8 > 6'd17 || cnt1 > 3'd3 || cnt16 > 7'd33) begin
        n_err++;
        $display("FAIL random_range cycle %0d: got %0d/%0d/%0d max 17/3/33", i, cnt8, cnt1, cnt16);
      end
    end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    rst = 1'b1;
    m8 = 0;
    m1 = 0;
    m16 = 0;
    test_reset();
    test_count_up();
    test_wrap();
    test_mid_reset();
    test_param_sweep();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
